// File: rtl/formula_2_distributor.sv
// Round-robin dispatcher/collector for a bank of formula_2_fsm workers.
// Hands each accepted (a,b,c) set to the worker at wr_ptr. Buffers worker
// results and re-emits them strictly in acceptance order, starting at rd_ptr.
module formula_2_distributor #(
  parameter int unsigned N_WORKERS = 4,
  parameter int unsigned W         = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arg_vld,
  input  logic [W-1:0]                     a,
  input  logic [W-1:0]                     b,
  input  logic [W-1:0]                     c,
  output logic                             arg_rdy,
  output logic                             res_vld,
  output logic [W-1:0]                     res,
  output logic [N_WORKERS-1:0]             w_arg_vld,
  output logic [W-1:0]                     w_a,
  output logic [W-1:0]                     w_b,
  output logic [W-1:0]                     w_c,
  input  logic [N_WORKERS-1:0]             w_res_vld,
  input  logic [N_WORKERS*W-1:0]           w_res,
  output logic [$clog2(N_WORKERS+1)-1:0]   in_flight,
  output logic                             drop_err,
  output logic                             spur_err
);

  localparam int unsigned PW = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int unsigned CW = $clog2(N_WORKERS + 1);

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(N_WORKERS - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  ptr_t                          wr_ptr_q, wr_ptr_d;
  ptr_t                          rd_ptr_q, rd_ptr_d;
  logic [N_WORKERS-1:0]          busy_q, busy_d;
  logic [N_WORKERS-1:0]          done_q, done_d;
  logic [N_WORKERS-1:0][W-1:0]   hold_q, hold_d;
  logic [W-1:0]                  res_q, res_d;
  logic                          res_vld_q, res_vld_d;
  logic [CW-1:0]                 in_flight_q, in_flight_d;
  logic                          drop_err_q, drop_err_d;
  logic                          spur_err_q, spur_err_d;

  logic [N_WORKERS-1:0][W-1:0]   w_res_v;
  logic                          accept;
  logic                          bypass;
  logic                          emit;

  assign w_res_v = w_res;

  // Readiness depends on registered state only, so a slot freed by an emit
  // becomes usable one cycle after the emit edge.
  assign arg_rdy = ~busy_q[wr_ptr_q];
  assign accept  = arg_vld & arg_rdy;
  assign bypass  = w_res_vld[rd_ptr_q] & busy_q[rd_ptr_q];
  assign emit    = done_q[rd_ptr_q] | bypass;

  assign w_a = a;
  assign w_b = b;
  assign w_c = c;

  // One-hot start pulse to the worker at wr_ptr; suppressed while in reset
  always_comb begin
    w_arg_vld = '0;
    if (accept && !rst) begin
      w_arg_vld[wr_ptr_q] = 1'b1;
    end
  end

  // Next-state: dispatch, capture, in-order emit, occupancy and sticky errors
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    hold_d      = hold_q;
    res_d       = res_q;
    res_vld_d   = 1'b0;
    in_flight_d = in_flight_q;
    drop_err_d  = drop_err_q;
    spur_err_d  = spur_err_q;

    for (int unsigned i = 0; i < N_WORKERS; i++) begin
      if (w_res_vld[i] && busy_q[i]) begin
        hold_d[i] = w_res_v[i];
        done_d[i] = 1'b1;
      end
    end

    if (accept) begin
      busy_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    // Emit is applied after capture so a bypassed result never leaves done set.
    // accept and emit cannot target the same slot: one needs busy=0, the other busy=1.
    if (emit) begin
      res_vld_d        = 1'b1;
      res_d            = done_q[rd_ptr_q] ? hold_q[rd_ptr_q] : w_res_v[rd_ptr_q];
      busy_d[rd_ptr_q] = 1'b0;
      done_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ptr_inc(rd_ptr_q);
    end

    case ({accept, emit})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase

    if (arg_vld && !arg_rdy) begin
      drop_err_d = 1'b1;
    end
    if (|(w_res_vld & ~busy_q)) begin
      spur_err_d = 1'b1;
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      hold_q      <= '0;
      res_q       <= '0;
      res_vld_q   <= 1'b0;
      in_flight_q <= '0;
      drop_err_q  <= 1'b0;
      spur_err_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      res_q       <= res_d;
      res_vld_q   <= res_vld_d;
      in_flight_q <= in_flight_d;
      drop_err_q  <= drop_err_d;
      spur_err_q  <= spur_err_d;
    end
  end

  assign res_vld   = res_vld_q;
  assign res       = res_q;
  assign in_flight = in_flight_q;
  assign drop_err  = drop_err_q;
  assign spur_err  = spur_err_q;

endmodule
